seq_adder_32: RTL and testbench

Iterative multi-cycle adder: accepts two WIDTH-bit operands over a valid/ready handshake and produces sum, carry-out and signed overflow. Processes one 4-bit nibble per cycle through a single carry-lookahead add slice, LSB nibble first, with the carry held in a register between nibbles. It is the addition counterpart to the 4-bit borrow-lookahead subtract slice. It serves as the low-area ALU add path where a full-width combinational adder is too costly.

---
 rtl/seq_adder_32_pkg.sv | 25 ++
 rtl/seq_adder_32_if.sv | 45 ++++
 rtl/seq_adder_32_cla_add_4bits.sv | 39 +++
 rtl/seq_adder_32.sv | 135 +++++++++++++
 tb/tb_seq_adder_32.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_adder_32_pkg.sv
// rtl/seq_adder_32_pkg.sv - shared types, constants and helpers for seq_adder_32
// Purpose: FSM state encoding, nibble width and counter-width helper shared by
//          the interface, the add slice and the top level.
package seq_adder_32_pkg;

  // Width of one add slice; the operand is consumed one slice per cycle.
  localparam int NIB_W = 4;

  // FSM state codes, kept as plain constants so older tools can use them too.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_BUSY = BUSY,
    ST_DONE = DONE
  } state_e;

  // Bits needed to count the WIDTH/4 nibbles of an operand.
  function automatic int cnt_w(input int width);
    return (width / NIB_W > 1) ? $clog2(width / NIB_W) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_32_if.sv
// rtl/seq_adder_32_if.sv - operand/result handshake bundle for seq_adder_32
// Purpose: groups the operand request channel and the result channel.
// Signals:
//   in_valid/in_ready  operand handshake (a, b, cin, and op when SEQ_ADDER_SUB_EN)
//   out_valid/out_ready result handshake (sum, cout, ovf)
// Modports: master = operand producer / result consumer, slave = the adder.
// Macro: SEQ_ADDER_SUB_EN adds the op signal (0 add, 1 subtract).
interface seq_adder_32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SEQ_ADDER_SUB_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SEQ_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/seq_adder_32_cla_add_4bits.sv
// rtl/seq_adder_32_cla_add_4bits.sv - combinational 4-bit carry-lookahead add slice
// Purpose: adds two nibbles plus a carry-in with lookahead carries.
// Ports:
//   x, y  in  4  addend nibbles
//   c0    in  1  carry-in
//   s     out 4  nibble sum
//   c3    out 1  carry into bit 3 (for signed overflow)
//   c4    out 1  carry out of bit 3
//   gm,pm out 1  group generate / propagate
module cla_add_4bits (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4,
  output logic       gm,
  output logic       pm
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  // Inclusive-OR propagate is valid for carries; the sum still needs x^y.
  assign g = x & y;
  assign p = x | y;

  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

  assign gm = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pm = &p;
  assign c4 = gm | (pm & c0);

  assign s = x ^ y ^ {c3, c2, c1, c0};

endmodule

// File: rtl/seq_adder_32.sv
// rtl/seq_adder_32.sv - iterative nibble-serial adder with valid/ready handshake
// Purpose: adds two WIDTH-bit operands one 4-bit nibble per cycle, LSB first,
//          reporting sum, unsigned carry-out and signed overflow.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    seq_adder_32_if.slave (operand and result handshakes)
// Parameter: WIDTH, multiple of 4 and at least 8.
// Macro: SEQ_ADDER_SUB_EN enables op (1 = subtract: b inverted, carry-in forced 1).
module seq_adder_32
  import seq_adder_32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_adder_32_if.slave  bus
);
  localparam int NIB = WIDTH / NIB_W;
  localparam int CW  = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef SEQ_ADDER_SUB_EN
  assign b_eff   = bus.op ? ~bus.b : bus.b;
  assign cin_eff = bus.op | bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  // Nibble mux feeding the single shared slice.
  logic [NIB_W-1:0] slice_x;
  logic [NIB_W-1:0] slice_y;
  logic [NIB_W-1:0] slice_s;
  logic             slice_c3;
  logic             slice_c4;
  logic             slice_gm;
  logic             slice_pm;

  assign slice_x = a_q[NIB_W*cnt_q +: NIB_W];
  assign slice_y = b_q[NIB_W*cnt_q +: NIB_W];

  cla_add_4bits u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .c0 (carry_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .c4 (slice_c4),
    .gm (slice_gm),
    .pm (slice_pm)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = b_eff;
          carry_d = cin_eff;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[NIB_W*cnt_q +: NIB_W] = slice_s;
        // Group generate/propagate form of the slice carry-out.
        carry_d = slice_gm | (slice_pm & carry_q);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = slice_c4;
          ovf_d   = slice_c3 ^ slice_c4;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_adder_32.sv
// tb/tb_seq_adder_32.sv - self-checking bench for seq_adder_32
module tb_seq_adder_32;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seq_adder_32_if #(.WIDTH(32)) bus32 ();
  seq_adder_32_if #(.WIDTH(8))  bus8 ();

  seq_adder_32 #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  seq_adder_32 #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        op;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    bus32.a        = v.a;
    bus32.b        = v.b;
    bus32.cin      = v.cin;
`ifdef SEQ_ADDER_SUB_EN
    bus32.op       = v.op;
`endif
    bus32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge; the adder must ignore them.
    bus32.in_valid = 1'b0;
    bus32.a        = ~v.a;
    bus32.b        = 32'h5555_AAAA;
    bus32.cin      = ~v.cin;
`ifdef SEQ_ADDER_SUB_EN
    bus32.op       = ~v.op;
`endif
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus32.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus32.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] hold_sum;
    logic        hold_co;
    logic        hold_ov;
    vec_t        v;

    tests = 0;
    fails = 0;

    //        a             b             cin   op    sum           co    ov
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0});
    vecs.push_back('{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0});
`ifdef SEQ_ADDER_SUB_EN
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
`endif

    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    bus32.op = 1'b0;
    bus8.op  = 1'b0;
`endif

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready",  32'(bus32.in_ready),  32'd1);
    check("reset out_valid", 32'(bus32.out_valid), 32'd0);
    check("reset sum",       bus32.sum,            32'd0);
    check("reset cout",      32'(bus32.cout),      32'd0);
    check("reset ovf",       32'(bus32.ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i]);
      wait_valid(lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'd8);
      check($sformatf("v%0d sum", i),  bus32.sum,        vecs[i].s);
      check($sformatf("v%0d cout", i), 32'(bus32.cout),  32'(vecs[i].co));
      check($sformatf("v%0d ovf", i),  32'(bus32.ovf),   32'(vecs[i].ov));
      finish_op();
      check($sformatf("v%0d in_ready after handshake", i), 32'(bus32.in_ready), 32'd1);
    end

    // Back-pressure: result held while out_ready is low, new operands refused.
    v = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    start_op(v);
    wait_valid(lat);
    hold_sum = bus32.sum;
    hold_co  = bus32.cout;
    hold_ov  = bus32.ovf;
    check("bp sum", hold_sum, 32'h8000_0000);
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.a        = 32'h1;
    bus32.b        = 32'h1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d out_valid", k), 32'(bus32.out_valid), 32'd1);
      check($sformatf("bp%0d in_ready", k),  32'(bus32.in_ready),  32'd0);
      check($sformatf("bp%0d sum", k),       bus32.sum,            32'h8000_0000);
      check($sformatf("bp%0d cout", k),      32'(bus32.cout),      32'(hold_co));
      check($sformatf("bp%0d ovf", k),       32'(bus32.ovf),       32'(hold_ov));
    end
    @(negedge clk);
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus32.out_ready = 1'b0;
    check("bp release in_ready",  32'(bus32.in_ready),  32'd1);
    check("bp release out_valid", 32'(bus32.out_valid), 32'd0);

    // Reset during the third BUSY cycle.
    v = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    start_op(v);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst partial sum nonzero", 32'(bus32.sum != 0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus32.out_valid), 32'd0);
    check("midrst sum",       bus32.sum,            32'd0);
    check("midrst in_ready",  32'(bus32.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
    start_op(v);
    wait_valid(lat);
    check("postrst latency", 32'(lat),        32'd8);
    check("postrst sum",     bus32.sum,       32'h0000_0010);
    check("postrst cout",    32'(bus32.cout), 32'd0);
    finish_op();

    // WIDTH=8 instance: two nibbles.
    @(negedge clk);
    bus8.a        = 8'hF0;
    bus8.b        = 8'h20;
    bus8.cin      = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.a        = 8'h00;
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w8 latency", 32'(lat),       32'd2);
    check("w8 sum",     32'(bus8.sum),  32'h10);
    check("w8 cout",    32'(bus8.cout), 32'd1);
    check("w8 ovf",     32'(bus8.ovf),  32'd0);
    @(negedge clk);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    check("w8 in_ready after handshake", 32'(bus8.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
